fft_bfly_sched: RTL and testbench

In-place radix-2 DIT FFT scheduler that sequences the shared `butterfly` datapath over an N-point dual-port data RAM. It issues one butterfly per cycle, generating the x/y read addresses and the twiddle-ROM index. It then replays the same addresses as write-backs after the datapath latency. Between stages it drains the pipeline so read-after-write hazards cannot occur. It sits between the FFT top-level control (start/done) and the RAM, twiddle ROM and `butterfly` instance.

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_bfly_sched_if.sv | 22 ++
 rtl/fft_delay_line.sv | 25 ++
 rtl/fft_bfly_sched.sv | 133 +++++++++++++
 tb/tb_fft_bfly_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the radix-2 FFT butterfly scheduler
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FFT_STAGE_W = 5;

  // Values driven on the address/twiddle outputs whenever their enable is low.
  localparam int ADDR_RST = 0;
  localparam int TW_RST   = 0;

endpackage

// File: rtl/fft_bfly_sched_if.sv
// rtl/fft_bfly_sched_if.sv - read/twiddle and write-back address bus between scheduler and RAM/ROM
interface fft_bfly_sched_if #(
  parameter int LOG2N = 10
);
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_x;
  logic [LOG2N-1:0] rd_addr_y;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_x;
  logic [LOG2N-1:0] wr_addr_y;

  modport master (
    output rd_en, rd_addr_x, rd_addr_y, tw_idx,
    output wr_en, wr_addr_x, wr_addr_y
  );

  modport slave (
    input rd_en, rd_addr_x, rd_addr_y, tw_idx,
    input wr_en, wr_addr_x, wr_addr_y
  );
endinterface

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - fixed-depth shift register with asynchronous clear
module fft_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// rtl/fft_bfly_sched.sv - in-place radix-2 DIT FFT butterfly address/twiddle scheduler
// Optional inverse-transform twiddle conjugation: FFT_SCHED_INV_EN.
module fft_bfly_sched
  import fft_pkg::*;
#(
  parameter int LOG2N    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef FFT_SCHED_INV_EN
  input  logic                   inverse,
  output logic                   tw_conj,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [FFT_STAGE_W-1:0] stage,
  fft_bfly_sched_if.master       bus
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int LW = 1 + 2 * AW;

  state_e                 state, state_nxt;
  logic [KW-1:0]          k;
  logic [FFT_STAGE_W-1:0] s;
  logic [DW-1:0]          drain;
  logic                   k_last, s_last, drain_last;
  logic                   rd_en;

  assign k_last     = &k;
  assign s_last     = (s == FFT_STAGE_W'(LOG2N - 1));
  assign drain_last = (drain == DW'(PIPE_LAT - 1));
  assign rd_en      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (k_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = s_last ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // k wraps to zero on the last issue of a stage, ready for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      s     <= '0;
      drain <= '0;
    end else begin
      case (state)
        IDLE: begin
          k     <= '0;
          s     <= '0;
          drain <= '0;
        end
        RUN: begin
          k     <= k + KW'(1);
          drain <= '0;
        end
        DRAIN: begin
          drain <= drain + DW'(1);
          if (drain_last) s <= s + FFT_STAGE_W'(1);
        end
        default: s <= '0;
      endcase
    end
  end

  logic [AW-1:0]          kx, span, pos, grp, ax, ay;
  logic [FFT_STAGE_W-1:0] tw_sh;
  logic [KW-1:0]          tw;

  // x inserts a zero at bit s of k, y sets it; twiddle index scales pos to N/2.
  always_comb begin
    kx    = AW'(k);
    span  = AW'(1) << s;
    pos   = kx & (span - AW'(1));
    grp   = kx >> s;
    ax    = (grp << (s + FFT_STAGE_W'(1))) | pos;
    ay    = ax + span;
    tw_sh = FFT_STAGE_W'(KW) - s;
    tw    = KW'(pos << tw_sh);
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_x = rd_en ? ax : AW'(ADDR_RST);
  assign bus.rd_addr_y = rd_en ? ay : AW'(ADDR_RST);
  assign bus.tw_idx    = rd_en ? tw : KW'(TW_RST);

  logic [LW-1:0] wr_word;

  fft_delay_line #(
    .W     (LW),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({bus.rd_en, bus.rd_addr_x, bus.rd_addr_y}),
    .dout  (wr_word)
  );

  assign bus.wr_en     = wr_word[LW-1];
  assign bus.wr_addr_x = wr_word[2*AW-1:AW];
  assign bus.wr_addr_y = wr_word[AW-1:0];

  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);
  assign stage = busy ? s : '0;

`ifdef FFT_SCHED_INV_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        inv_q <= 1'b0;
    else if (state == IDLE && start)   inv_q <= inverse;
  end

  assign tw_conj = busy & inv_q;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// tb/tb_fft_bfly_sched.sv - self-checking bench: per-cycle schedule model plus hand-computed pins
module tb_fft_bfly_sched;

  localparam int LG_A = 3, PL_A = 2;
  localparam int LG_B = 2, PL_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic inverse = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [4:0] stage_a, stage_b;
  logic tw_conj_a, tw_conj_b;

  always #5 clk = ~clk;

  fft_bfly_sched_if #(.LOG2N(LG_A)) if_a ();
  fft_bfly_sched_if #(.LOG2N(LG_B)) if_b ();

`ifndef FFT_SCHED_INV_EN
  assign tw_conj_a = 1'b0;
  assign tw_conj_b = 1'b0;
`endif

  fft_bfly_sched #(.LOG2N(LG_A), .PIPE_LAT(PL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef FFT_SCHED_INV_EN
    .inverse(inverse), .tw_conj(tw_conj_a),
`endif
    .busy(busy_a), .done(done_a), .stage(stage_a), .bus(if_a)
  );

  fft_bfly_sched #(.LOG2N(LG_B), .PIPE_LAT(PL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef FFT_SCHED_INV_EN
    .inverse(inverse), .tw_conj(tw_conj_b),
`endif
    .busy(busy_b), .done(done_b), .stage(stage_b), .bus(if_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual %0d required %0d", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic rd;
    int   x;
    int   y;
    int   tw;
  } slot_t;

  // Read issued in cycle rel (1-based from the start accept) of a transform.
  function automatic slot_t read_slot(int lg, int pl, int rel);
    int h, per, s, o, span;
    slot_t r;
    r = '0;
    h = 1 << (lg - 1);
    per = h + pl;
    if (rel >= 1 && rel <= lg * per) begin
      s = (rel - 1) / per;
      o = (rel - 1) % per;
      if (o < h) begin
        span = 1 << s;
        r.rd = 1'b1;
        r.x  = (o / span) * 2 * span + o % span;
        r.y  = r.x + span;
        r.tw = (o % span) * (h / span);
      end
    end
    return r;
  endfunction

  // Model state: whether a transform has been accepted and the cycle it began.
  int cyc = 0;
  bit a_act = 0, b_act = 0;
  int a_t0 = 0, b_t0 = 0;
  bit a_inv = 0, b_inv = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_act <= 1'b0;
      b_act <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (start_a && !(a_act && (cyc - a_t0 + 1) <= LG_A * ((1 << (LG_A - 1)) + PL_A) + 1)) begin
        a_act <= 1'b1;
        a_t0  <= cyc + 1;
        a_inv <= inverse;
      end
      if (start_b && !(b_act && (cyc - b_t0 + 1) <= LG_B * ((1 << (LG_B - 1)) + PL_B) + 1)) begin
        b_act <= 1'b1;
        b_t0  <= cyc + 1;
        b_inv <= inverse;
      end
    end
  end

  task automatic chk_all(input string tag, input int lg, input int pl, input bit act, input int rel,
                         input bit inv, input logic busy, input logic done, input logic [31:0] stg,
                         input logic tconj, input logic rd, input logic [31:0] rx, input logic [31:0] ry,
                         input logic [31:0] tw, input logic wr, input logic [31:0] wx, input logic [31:0] wy);
    int b_len, per;
    slot_t r, w;
    bit e_busy, e_done;
    int e_stage;
    per   = (1 << (lg - 1)) + pl;
    b_len = lg * per;
    r = '0; w = '0; e_busy = 0; e_done = 0; e_stage = 0;
    if (act) begin
      r = read_slot(lg, pl, rel);
      w = read_slot(lg, pl, rel - pl);
      e_busy = (rel >= 1 && rel <= b_len);
      e_done = (rel == b_len + 1);
      if (e_busy) e_stage = (rel - 1) / per;
    end
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".stage"}, stg, e_stage);
    chk({tag, ".rd_en"}, 32'(rd), 32'(r.rd));
    chk({tag, ".rd_addr_x"}, rx, r.x);
    chk({tag, ".rd_addr_y"}, ry, r.y);
    chk({tag, ".tw_idx"}, tw, r.tw);
    chk({tag, ".wr_en"}, 32'(wr), 32'(w.rd));
    chk({tag, ".wr_addr_x"}, wx, w.x);
    chk({tag, ".wr_addr_y"}, wy, w.y);
`ifdef FFT_SCHED_INV_EN
    chk({tag, ".tw_conj"}, 32'(tconj), 32'(e_busy && inv));
`else
    if (tconj !== 1'b0) chk({tag, ".tw_conj_tie"}, 32'(tconj), 0);
`endif
  endtask

  // Capture hooks used by the directed pins below.
  bit cap_a = 0, cap_b = 0, cnt_done = 0, cnt_wr = 0;
  int cap_x[$], cap_y[$], cap_tw[$];
  int a_busy_n = 0, a_done_at = -1, b_busy_n = 0, done_n = 0, wr_n = 0;

  always @(negedge clk) begin
    chk_all("a", LG_A, PL_A, a_act, cyc - a_t0 + 1, a_inv, busy_a, done_a, 32'(stage_a), tw_conj_a,
            if_a.rd_en, 32'(if_a.rd_addr_x), 32'(if_a.rd_addr_y), 32'(if_a.tw_idx),
            if_a.wr_en, 32'(if_a.wr_addr_x), 32'(if_a.wr_addr_y));
    chk_all("b", LG_B, PL_B, b_act, cyc - b_t0 + 1, b_inv, busy_b, done_b, 32'(stage_b), tw_conj_b,
            if_b.rd_en, 32'(if_b.rd_addr_x), 32'(if_b.rd_addr_y), 32'(if_b.tw_idx),
            if_b.wr_en, 32'(if_b.wr_addr_x), 32'(if_b.wr_addr_y));
    if (cap_a) begin
      if (busy_a === 1'b1) a_busy_n++;
      if (done_a === 1'b1) a_done_at = a_busy_n;
      if (if_a.rd_en === 1'b1) begin
        cap_x.push_back(int'(if_a.rd_addr_x));
        cap_y.push_back(int'(if_a.rd_addr_y));
        cap_tw.push_back(int'(if_a.tw_idx));
      end
    end
    if (cap_b && busy_b === 1'b1) b_busy_n++;
    if (cnt_done && done_a === 1'b1) done_n++;
    if (cnt_wr && if_a.wr_en !== 1'b0) wr_n++;
  end

  int pin_x[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int pin_y[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int pin_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    slot_t m;
    tick(3);
    #1 rst_n = 1'b1;

    // Single transform on both instances; a start pulse mid-run must be ignored.
    tick(1);
    start_a = 1'b1; start_b = 1'b1; inverse = 1'b1; cap_a = 1; cap_b = 1;
    tick(1);
    start_a = 1'b0; start_b = 1'b0;
    tick(4);
    start_a = 1'b1; inverse = 1'b0;
    tick(1);
    start_a = 1'b0;
    tick(25);
    cap_a = 0; cap_b = 0;

    chk("pin.n_issue", cap_x.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < cap_x.size()) begin
        chk($sformatf("pin.x%0d", i), cap_x[i], pin_x[i]);
        chk($sformatf("pin.y%0d", i), cap_y[i], pin_y[i]);
        chk($sformatf("pin.tw%0d", i), cap_tw[i], pin_tw[i]);
      end
      m = read_slot(LG_A, PL_A, (i / 4) * 6 + (i % 4) + 1);
      chk($sformatf("model.x%0d", i), m.x, pin_x[i]);
      chk($sformatf("model.y%0d", i), m.y, pin_y[i]);
      chk($sformatf("model.tw%0d", i), m.tw, pin_tw[i]);
    end
    chk("pin.busy_len_a", a_busy_n, 18);
    chk("pin.done_after_busy", a_done_at, 18);
    chk("pin.busy_len_b", b_busy_n, 6);

    // start held high: back-to-back transforms separated by one idle cycle.
    cnt_done = 1; start_a = 1'b1;
    tick(45);
    cnt_done = 0; start_a = 1'b0;
    chk("pin.held_done_count", done_n, 2);
    tick(30);

    // Reset in stage 1 cycle 3: everything clears at once, no late write-back.
    inverse = 1'b1;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(8);
    chk("pin.pre_rst_stage", 32'(stage_a), 1);
    chk("pin.pre_rst_rd", 32'(if_a.rd_en), 1);
    #1 rst_n = 1'b0; cnt_wr = 1;
    #1;
    chk("pin.rst_busy_now", 32'(busy_a), 0);
    chk("pin.rst_rd_now", 32'(if_a.rd_en), 0);
    chk("pin.rst_wr_now", 32'(if_a.wr_en), 0);
    chk("pin.rst_stage_now", 32'(stage_a), 0);
    tick(3);
    #1 rst_n = 1'b1;
    tick(5);
    cnt_wr = 0;
    chk("pin.no_wr_after_rst", wr_n, 0);

    // Restart after reset runs the full sequence.
    a_busy_n = 0; a_done_at = -1; cap_a = 1;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(25);
    cap_a = 0;
    chk("pin.restart_busy_len", a_busy_n, 18);
    chk("pin.restart_done", a_done_at, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
